// File: rtl/mackerel_bus_pkg.sv
// Shared types and helpers for the Mackerel-30 bus initiator: state encoding,
// operand size codes, DSACK port-width codes and byte-lane steering functions.
package mackerel_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        S0,
        S1,
        WAIT,
        S_END,
        RECOV
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_LONG = 2'b00;

    // Port width as seen on {DSACK1_n, DSACK0_n}
    localparam logic [1:0] PORT_8  = 2'b10;
    localparam logic [1:0] PORT_16 = 2'b01;
    localparam logic [1:0] PORT_32 = 2'b00;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_WORD: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

    // Operand byte k, counted from the most significant byte of a right-justified operand
    function automatic logic [7:0] op_byte(input logic [31:0] data, input logic [2:0] nbytes,
                                           input logic [2:0] k);
        logic [2:0] idx;
        idx = nbytes - 3'd1 - k;
        return data[{idx[1:0], 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] write_lanes(input logic [31:0] data, input logic [2:0] nbytes,
                                                input logic [2:0] p, input logic [2:0] r,
                                                input logic [1:0] a);
        logic [31:0] lanes;
        logic [2:0]  o;
        lanes = '0;
        for (int j = 0; j < 4; j++) begin
            o = {1'b0, a} + 3'(j);
            if ((3'(j) < r) && (o < 3'd4))
                lanes[{~o[1:0], 3'b000} +: 8] = op_byte(data, nbytes, p + 3'(j));
        end
        // Narrow ports only see the upper lanes, so mirror the leading bytes there
        lanes[31:24] = op_byte(data, nbytes, p);
        if (a[0])
            lanes[23:16] = op_byte(data, nbytes, p);
        else if (r >= 3'd2)
            lanes[23:16] = op_byte(data, nbytes, p + 3'd1);
        return lanes;
    endfunction

    function automatic logic [31:0] read_merge(input logic [31:0] rbuf, input logic [31:0] din,
                                               input logic [2:0] nbytes, input logic [2:0] p,
                                               input logic [2:0] n, input logic [1:0] base);
        logic [31:0] res;
        logic [2:0]  o;
        logic [2:0]  idx;
        res = rbuf;
        for (int j = 0; j < 4; j++) begin
            if (3'(j) < n) begin
                o   = {1'b0, base} + 3'(j);
                idx = nbytes - 3'd1 - (p + 3'(j));
                res[{idx[1:0], 3'b000} +: 8] = din[{~o[1:0], 3'b000} +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous active-low bus terminations and grants.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bus_initiator.sv
// 68030-style bus-master engine with dynamic bus sizing for on-chip clients.
// Optional bus arbitration (BR_n/BG_n/BGACK_n, ARB state) is enabled by defining BUS_ARB_EN.
module bus_initiator
    import mackerel_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [2:0]  FC_VAL  = 3'b101
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        REQ,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    input  logic [1:0]  SIZE,
    input  logic        WR,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic [31:0] A,
    output logic [2:0]  FC,
    output logic        SIZ1,
    output logic        SIZ0,
    output logic        RW,
    output logic        AS_n,
    output logic        DS_n,
    output logic [31:0] D_OUT,
    output logic        D_OE,
    input  logic [31:0] D_IN,
    input  logic        DSACK0_n,
    input  logic        DSACK1_n,
    input  logic        BERR_n
`ifdef BUS_ARB_EN
    ,
    output logic        BR_n,
    input  logic        BG_n,
    output logic        BGACK_n
`endif
);

`ifdef BUS_ARB_EN
    localparam logic ARB_EN = 1'b1;
`else
    localparam logic ARB_EN = 1'b0;
`endif
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic [31:0] addr_q, wdata_q, rdBuf_q, rdBuf_d, rdata_q, a_q, dOut_q;
    logic [2:0]  nBytes_q, p_q, r_q, n_q;
    logic        wr_q, err_q;
    logic [15:0] tmo_q;
    logic [1:0]  siz_q;
    logic        rw_q, as_q, ds_q, dOe_q, done_q, errOut_q;
    logic        ds0Sync, ds1Sync, berrSync, termsHigh, goS0;
    logic [31:0] srcAddr, srcData, cycAddr, cycData;
    logic [2:0]  srcBytes, srcP, srcR, room, nTake;
    logic        srcWr;
    logic [1:0]  laneBase;

    sync2 uDs0  (.clk_i(CLK), .rst_ni(RST_n), .d_i(DSACK0_n), .q_o(ds0Sync));
    sync2 uDs1  (.clk_i(CLK), .rst_ni(RST_n), .d_i(DSACK1_n), .q_o(ds1Sync));
    sync2 uBerr (.clk_i(CLK), .rst_ni(RST_n), .d_i(BERR_n),   .q_o(berrSync));

`ifdef BUS_ARB_EN
    logic bgSync, br_q, bgack_q;
    sync2 uBg (.clk_i(CLK), .rst_ni(RST_n), .d_i(BG_n), .q_o(bgSync));
    assign BR_n    = br_q;
    assign BGACK_n = bgack_q;
`endif

    // A new bus cycle starts either from a fresh request or from the latched transfer
    always_comb begin
        if (state_q == IDLE) begin
            srcAddr  = ADDR;
            srcData  = WDATA;
            srcBytes = size_bytes(SIZE);
            srcWr    = WR;
            srcP     = 3'd0;
            srcR     = size_bytes(SIZE);
        end else begin
            srcAddr  = addr_q;
            srcData  = wdata_q;
            srcBytes = nBytes_q;
            srcWr    = wr_q;
            srcP     = p_q;
            srcR     = r_q;
        end
        cycAddr = srcAddr + {29'd0, srcP};
        cycData = write_lanes(srcData, srcBytes, srcP, srcR, cycAddr[1:0]);

        case ({ds1Sync, ds0Sync})
            PORT_32: begin laneBase = a_q[1:0];          room = 3'd4 - {1'b0, a_q[1:0]}; end
            PORT_16: begin laneBase = {1'b0, a_q[0]};    room = 3'd2 - {2'b00, a_q[0]}; end
            default: begin laneBase = 2'd0;              room = 3'd1; end
        endcase
        nTake   = (r_q < room) ? r_q : room;
        rdBuf_d = read_merge(rdBuf_q, D_IN, nBytes_q, p_q, nTake, laneBase);

        termsHigh = berrSync & ds0Sync & ds1Sync;
        case (state_q)
            IDLE:    goS0 = REQ && !ARB_EN;
`ifdef BUS_ARB_EN
            ARB:     goS0 = !bgSync;
`endif
            RECOV:   goS0 = termsHigh && (r_q != 3'd0) && !err_q;
            default: goS0 = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            nBytes_q <= '0;
            wr_q     <= 1'b0;
            p_q      <= '0;
            r_q      <= '0;
            n_q      <= '0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
            rdBuf_q  <= '0;
            rdata_q  <= '0;
            a_q      <= '0;
            dOut_q   <= '0;
            siz_q    <= 2'b00;
            rw_q     <= 1'b1;
            as_q     <= 1'b1;
            ds_q     <= 1'b1;
            dOe_q    <= 1'b0;
            done_q   <= 1'b0;
            errOut_q <= 1'b0;
`ifdef BUS_ARB_EN
            br_q     <= 1'b1;
            bgack_q  <= 1'b1;
`endif
        end else begin
            done_q   <= 1'b0;
            errOut_q <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef BUS_ARB_EN
                    bgack_q <= 1'b1;
`endif
                    if (REQ) begin
                        addr_q   <= ADDR;
                        wdata_q  <= WDATA;
                        nBytes_q <= srcBytes;
                        wr_q     <= WR;
                        p_q      <= 3'd0;
                        r_q      <= srcBytes;
                        err_q    <= 1'b0;
                        rdBuf_q  <= '0;
`ifdef BUS_ARB_EN
                        state_q  <= ARB;
                        br_q     <= 1'b0;
`endif
                    end
                end
`ifdef BUS_ARB_EN
                ARB: begin
                    if (!bgSync) begin
                        br_q    <= 1'b1;
                        bgack_q <= 1'b0;
                    end
                end
`endif
                S0: begin
                    state_q <= S1;
                    as_q    <= 1'b0;
                    ds_q    <= wr_q;
                end
                S1: begin
                    state_q <= WAIT;
                    ds_q    <= 1'b0;
                    tmo_q   <= '0;
                end
                WAIT: begin
                    // A DSACK arriving on the last timeout clock still wins over the timeout
                    if (!berrSync || (ds0Sync && ds1Sync && tmo_q == TMO_LAST)) begin
                        err_q   <= 1'b1;
                        n_q     <= 3'd0;
                        state_q <= S_END;
                        as_q    <= 1'b1;
                        ds_q    <= 1'b1;
                        dOe_q   <= 1'b0;
                    end else if (!ds0Sync || !ds1Sync) begin
                        n_q     <= nTake;
                        if (!wr_q)
                            rdBuf_q <= rdBuf_d;
                        state_q <= S_END;
                        as_q    <= 1'b1;
                        ds_q    <= 1'b1;
                        dOe_q   <= 1'b0;
                    end else begin
                        tmo_q   <= tmo_q + 16'd1;
                    end
                end
                S_END: begin
                    p_q     <= p_q + n_q;
                    r_q     <= r_q - n_q;
                    state_q <= RECOV;
                end
                RECOV: begin
                    if (termsHigh && (r_q == 3'd0 || err_q)) begin
                        done_q   <= 1'b1;
                        errOut_q <= err_q;
                        rdata_q  <= rdBuf_q;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (goS0) begin
                state_q <= S0;
                a_q     <= cycAddr;
                siz_q   <= srcR[1:0];
                rw_q    <= ~srcWr;
                dOut_q  <= cycData;
                dOe_q   <= srcWr;
            end
        end
    end

    assign DONE  = done_q;
    assign ERR   = errOut_q;
    assign RDATA = rdata_q;
    assign A     = a_q;
    assign FC    = FC_VAL;
    assign SIZ1  = siz_q[1];
    assign SIZ0  = siz_q[0];
    assign RW    = rw_q;
    assign AS_n  = as_q;
    assign DS_n  = ds_q;
    assign D_OUT = dOut_q;
    assign D_OE  = dOe_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed, table-driven bench for bus_initiator with a DSACK/BERR-responding slave model.
// Builds with or without BUS_ARB_EN; with it, the grant simply follows the request.
module tb_bus_initiator;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        REQ = 1'b0;
    logic [31:0] ADDR = '0;
    logic [31:0] WDATA = '0;
    logic [1:0]  SIZE = 2'b00;
    logic        WR = 1'b0;
    logic        DONE, ERR;
    logic [31:0] RDATA, A, D_OUT;
    logic [2:0]  FC;
    logic        SIZ1, SIZ0, RW, AS_n, DS_n, D_OE;
    logic [31:0] D_IN = '0;
    logic        DSACK0_n = 1'b1;
    logic        DSACK1_n = 1'b1;
    logic        BERR_n = 1'b1;
`ifdef BUS_ARB_EN
    logic        BR_n, BGACK_n;
    logic        BG_n;
    assign BG_n = BR_n;
`endif

    bus_initiator dut (
        .CLK(CLK), .RST_n(RST_n), .REQ(REQ), .ADDR(ADDR), .WDATA(WDATA), .SIZE(SIZE), .WR(WR),
        .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .A(A), .FC(FC), .SIZ1(SIZ1), .SIZ0(SIZ0),
        .RW(RW), .AS_n(AS_n), .DS_n(DS_n), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
        .DSACK0_n(DSACK0_n), .DSACK1_n(DSACK1_n), .BERR_n(BERR_n)
`ifdef BUS_ARB_EN
        , .BR_n(BR_n), .BG_n(BG_n), .BGACK_n(BGACK_n)
`endif
    );

    always #5 CLK = ~CLK;

    int testsRun = 0;
    int testsFailed = 0;

    // Slave/monitor state
    logic        slaveOn = 1'b0;
    logic [1:0]  slavePort = 2'b00;
    int          berrCycle = -1;
    int          base = 0;
    int          asFalls = 0;
    logic        asPrev = 1'b1;
    logic [31:0] logA[128];
    logic [1:0]  logSiz[128];
    logic [31:0] logDout[128];
    logic        logRw[128];
    logic        logDoe[128];

    // Results of the last transfer
    logic        gotDone, gotErr;
    logic [31:0] gotRdata;
    int          gotCycles, gotElapsed;

    // Logs each bus cycle at AS_n assertion and answers it half a clock later
    always @(negedge CLK) begin
        asPrev <= AS_n;
        if (!AS_n && asPrev) begin
            logA[asFalls[6:0]]    <= A;
            logSiz[asFalls[6:0]]  <= {SIZ1, SIZ0};
            logDout[asFalls[6:0]] <= D_OUT;
            logRw[asFalls[6:0]]   <= RW;
            logDoe[asFalls[6:0]]  <= D_OE;
            asFalls <= asFalls + 1;
        end
        if (!AS_n && slaveOn) begin
            if (berrCycle == ((asPrev ? asFalls : asFalls - 1) - base)) begin
                BERR_n   <= 1'b0;
                DSACK1_n <= 1'b1;
                DSACK0_n <= 1'b1;
            end else begin
                BERR_n   <= 1'b1;
                DSACK1_n <= slavePort[1];
                DSACK0_n <= slavePort[0];
            end
        end else begin
            BERR_n   <= 1'b1;
            DSACK1_n <= 1'b1;
            DSACK0_n <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic wr, input logic [1:0] port,
                                 input logic [31:0] din, input int berrAt, input logic slave);
        int n;
        @(negedge CLK);
        ADDR = addr;
        WDATA = wdata;
        SIZE = size;
        WR = wr;
        D_IN = din;
        slavePort = port;
        berrCycle = berrAt;
        slaveOn = slave;
        base = asFalls;
        REQ = 1'b1;
        @(negedge CLK);
        REQ = 1'b0;
        gotDone = 1'b0;
        gotErr = 1'b0;
        gotRdata = '0;
        n = 1;
        while (!gotDone && n < 2000) begin
            if (DONE) begin
                gotDone = 1'b1;
                gotErr = ERR;
                gotRdata = RDATA;
            end else begin
                @(negedge CLK);
                n++;
            end
        end
        gotElapsed = n;
        gotCycles = asFalls - base;
        if (!gotDone) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL done-wait: got no DONE after %0d clocks, expected DONE", n);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        wr;
        logic [1:0]  port;
        logic [31:0] din;
        logic [31:0] expRdata;
        int          expCycles;
        logic [1:0]  expSiz0;
        logic [31:0] expDout0;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'hC0000000, 32'h0,        2'b00, 1'b0, 2'b00, 32'h12345678, 32'h12345678, 1, 2'b00, 32'h0};
        vecs[1]  = '{32'h80000002, 32'h0,        2'b10, 1'b0, 2'b01, 32'hBEEF0000, 32'h0000BEEF, 1, 2'b10, 32'h0};
        vecs[2]  = '{32'h00000003, 32'h0,        2'b01, 1'b0, 2'b00, 32'h111122AB, 32'h000000AB, 1, 2'b01, 32'h0};
        vecs[3]  = '{32'h00000005, 32'h0,        2'b01, 1'b0, 2'b01, 32'h12AB3344, 32'h000000AB, 1, 2'b01, 32'h0};
        vecs[4]  = '{32'h00000001, 32'h0,        2'b10, 1'b0, 2'b00, 32'h11AABB22, 32'h0000AABB, 1, 2'b10, 32'h0};
        vecs[5]  = '{32'h00000003, 32'h0,        2'b10, 1'b0, 2'b00, 32'hCC0000DD, 32'h0000DDCC, 2, 2'b10, 32'h0};
        vecs[6]  = '{32'h00000000, 32'h0,        2'b00, 1'b0, 2'b10, 32'h5A000000, 32'h5A5A5A5A, 4, 2'b00, 32'h0};
        vecs[7]  = '{32'h00000002, 32'h0,        2'b00, 1'b0, 2'b01, 32'h12340000, 32'h12341234, 2, 2'b00, 32'h0};
        vecs[8]  = '{32'h00000000, 32'hAABBCCDD, 2'b00, 1'b1, 2'b00, 32'h0,        32'h0,        1, 2'b00, 32'hAABBCCDD};
        vecs[9]  = '{32'h00000001, 32'h000000EE, 2'b01, 1'b1, 2'b00, 32'h0,        32'h0,        1, 2'b01, 32'hEEEE0000};
        vecs[10] = '{32'h00000002, 32'h00001234, 2'b10, 1'b1, 2'b01, 32'h0,        32'h0,        1, 2'b10, 32'h12341234};
        vecs[11] = '{32'h00000003, 32'h00005678, 2'b10, 1'b1, 2'b00, 32'h0,        32'h0,        2, 2'b10, 32'h56560056};

        // Reset state
        repeat (3) @(negedge CLK);
        checkOutput("reset-strobes", {31'd0, AS_n & DS_n & RW}, 32'd1);
        checkOutput("reset-flags", {29'd0, D_OE, DONE, ERR}, 32'd0);
        checkOutput("reset-A", A, 32'h0);
        checkOutput("reset-RDATA", RDATA, 32'h0);
        checkOutput("reset-DOUT", D_OUT, 32'h0);
        checkOutput("reset-FC-SIZ", {27'd0, FC, SIZ1, SIZ0}, {27'd0, 3'b101, 2'b00});
        RST_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].wr, vecs[i].port,
                          vecs[i].din, -1, 1'b1);
            checkOutput($sformatf("vec%0d-err", i), {31'd0, gotErr}, 32'd0);
            checkOutput($sformatf("vec%0d-cycles", i), gotCycles, vecs[i].expCycles);
            checkOutput($sformatf("vec%0d-A0", i), logA[7'(base)], vecs[i].addr);
            checkOutput($sformatf("vec%0d-SIZ0", i), {30'd0, logSiz[7'(base)]}, {30'd0, vecs[i].expSiz0});
            checkOutput($sformatf("vec%0d-RW", i), {31'd0, logRw[7'(base)]}, {31'd0, ~vecs[i].wr});
            if (vecs[i].wr) begin
                checkOutput($sformatf("vec%0d-DOUT0", i), logDout[7'(base)], vecs[i].expDout0);
                checkOutput($sformatf("vec%0d-DOE", i), {31'd0, logDoe[7'(base)]}, 32'd1);
            end else begin
                checkOutput($sformatf("vec%0d-RDATA", i), gotRdata, vecs[i].expRdata);
            end
        end

        // Long write to an 8-bit port: four cycles, one byte each
        applyStimulus(32'hF0000000, 32'hAABBCCDD, 2'b00, 1'b1, 2'b10, 32'h0, -1, 1'b1);
        checkOutput("wr8-cycles", gotCycles, 4);
        checkOutput("wr8-err", {31'd0, gotErr}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("wr8-A%0d", c), logA[7'(base + c)], 32'hF0000000 + 32'(c));
            checkOutput($sformatf("wr8-SIZ%0d", c), {30'd0, logSiz[7'(base + c)]}, 32'((4 - c) % 4));
            checkOutput($sformatf("wr8-D%0d", c), {24'd0, logDout[7'(base + c)][31:24]},
                        {24'd0, 8'hAA + 8'(c * 8'h11)});
        end

        // Misaligned long read to a 32-bit port: 3 bytes then 1 byte
        applyStimulus(32'h00000001, 32'h0, 2'b00, 1'b0, 2'b00, 32'h11223344, -1, 1'b1);
        checkOutput("mis-cycles", gotCycles, 2);
        checkOutput("mis-A1", logA[7'(base + 1)], 32'h00000004);
        checkOutput("mis-SIZ1", {30'd0, logSiz[7'(base + 1)]}, 32'd1);
        checkOutput("mis-RDATA", gotRdata, 32'h22334411);
        @(negedge CLK);
        checkOutput("done-pulse", {31'd0, DONE}, 32'd0);

        // Bus error on the second cycle of a byte-split long read
        applyStimulus(32'h00000010, 32'h0, 2'b00, 1'b0, 2'b10, 32'h77000000, 1, 1'b1);
        checkOutput("berr-err", {31'd0, gotErr}, 32'd1);
        repeat (10) @(negedge CLK);
        checkOutput("berr-cycles", asFalls - base, 2);

        // No termination at all: internal timeout
        applyStimulus(32'h00000020, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, -1, 1'b0);
        checkOutput("tmo-err", {31'd0, gotErr}, 32'd1);
        checkOutput("tmo-cycles", gotCycles, 1);
        checkOutput("tmo-latency", {31'd0, (gotElapsed >= 255) && (gotElapsed <= 275)}, 32'd1);

        // Asynchronous reset while the bus cycle is stuck in WAIT
        @(negedge CLK);
        ADDR = 32'h00000040;
        SIZE = 2'b00;
        WR = 1'b0;
        slaveOn = 1'b0;
        REQ = 1'b1;
        @(negedge CLK);
        REQ = 1'b0;
        begin
            int n;
            n = 0;
            while (AS_n && n < 20) begin
                @(negedge CLK);
                n++;
            end
            checkOutput("rst-AS-seen", {31'd0, AS_n}, 32'd0);
        end
        repeat (3) @(negedge CLK);
        #2 RST_n = 1'b0;
        #1;
        checkOutput("rst-async-strobes", {30'd0, AS_n, DS_n}, 32'd3);
        checkOutput("rst-async-doe", {31'd0, D_OE}, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        applyStimulus(32'hC0000000, 32'h0, 2'b00, 1'b0, 2'b00, 32'h12345678, -1, 1'b1);
        checkOutput("post-rst-RDATA", gotRdata, 32'h12345678);
        checkOutput("post-rst-err", {31'd0, gotErr}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
